// File: rtl/clk_rst_pkg.sv
// clk_rst_pkg: shared reset-sequencer state encoding and parameter defaults
package clk_rst_pkg;
    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        PERIPH    = 2'd2,
        RUN       = 2'd3
    } seq_state_t;
    localparam int STABLE_CYCLES_DEF = 1024;
    localparam int STAGE_GAP_DEF     = 16;
    localparam int SYNC_STAGES_DEF   = 2;
endpackage

// File: rtl/sync_ff.sv
// sync_ff: parameterised-depth single-bit synchroniser with sync active-low reset
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;
    // shift the asynchronous input through the flop chain
    always_ff @(posedge clk)
        ff <= !resetn ? '0 : {ff[STAGES-2:0], d};
    assign q = ff[STAGES-1];
endmodule

// File: rtl/pll_reset_seq.sv
// pll_reset_seq: PLL lock qualification and ordered reset release; LOCK_LOSS_CNT_EN enables loss_cnt
module pll_reset_seq
    import clk_rst_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
    parameter int STAGE_GAP     = STAGE_GAP_DEF,
    parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             locked,
    input  logic             clr,
    output logic             periph_resetn,
    output logic             core_resetn,
    output logic             ready,
    output logic             lock_lost,
    output logic [CNT_W-1:0] loss_cnt
);
    localparam int CW = $clog2(STABLE_CYCLES > STAGE_GAP ? STABLE_CYCLES : STAGE_GAP);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST    = CW'(STAGE_GAP - 1);
    seq_state_t    state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          locked_s;
    logic          loss;
    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (locked),
        .q      (locked_s)
    );
    // next state: qualify lock, pace the release, flag losses after qualification
    always_comb begin
        state_nx = state;
        cnt_nx   = '0;
        loss     = 1'b0;
        case (state)
            WAIT_LOCK: if (locked_s) state_nx = STABLE;
            STABLE:
                if (!locked_s) state_nx = WAIT_LOCK;
                else if (cnt == STABLE_LAST) state_nx = PERIPH;
                else cnt_nx = cnt + CW'(1);
            PERIPH:
                if (!locked_s) begin
                    state_nx = WAIT_LOCK;
                    loss     = 1'b1;
                end
                else if (cnt == GAP_LAST) state_nx = RUN;
                else cnt_nx = cnt + CW'(1);
            RUN:
                if (!locked_s) begin
                    state_nx = WAIT_LOCK;
                    loss     = 1'b1;
                end
            default: state_nx = WAIT_LOCK;
        endcase
    end
    // state and interval counter registers
    always_ff @(posedge clk) begin
        state <= !resetn ? WAIT_LOCK : state_nx;
        cnt   <= !resetn ? '0 : cnt_nx;
    end
    // sticky loss flag; a loss in the same cycle as clr is kept
    always_ff @(posedge clk)
        lock_lost <= !resetn ? 1'b0 : loss ? 1'b1 : clr ? 1'b0 : lock_lost;
`ifdef LOCK_LOSS_CNT_EN
    logic [CNT_W-1:0] loss_q;
    // saturating loss counter; clr coincident with a loss restarts the count at one
    always_ff @(posedge clk)
        loss_q <= !resetn ? '0 :
                  loss    ? (clr ? CNT_W'(1) : (&loss_q ? loss_q : loss_q + CNT_W'(1))) :
                  clr     ? '0 : loss_q;
    assign loss_cnt = loss_q;
`else
    assign loss_cnt = '0;
`endif
    assign periph_resetn = (state == PERIPH) || (state == RUN);
    assign core_resetn   = (state == RUN);
    assign ready         = (state == RUN);
endmodule

// File: tb/tb_pll_reset_seq.sv
// tb_pll_reset_seq: run-length lock model plus directed timing checks for pll_reset_seq
module tb_pll_reset_seq;
    localparam int S    = 16;
    localparam int G    = 4;
    localparam int CNTW = 2;
    localparam int CMAX = (1 << CNTW) - 1;
`ifdef LOCK_LOSS_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            locked = 1'b0;
    logic            clr = 1'b0;
    logic            periph_resetn, core_resetn, ready, lock_lost;
    logic [CNTW-1:0] loss_cnt;
    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    pll_reset_seq #(
        .STABLE_CYCLES (S),
        .STAGE_GAP     (G),
        .SYNC_STAGES   (2),
        .CNT_W         (CNTW)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .locked        (locked),
        .clr           (clr),
        .periph_resetn (periph_resetn),
        .core_resetn   (core_resetn),
        .ready         (ready),
        .lock_lost     (lock_lost),
        .loss_cnt      (loss_cnt)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    endtask
    // Model: a reset is released once locked_s has been high for enough
    // consecutive cycles; a loss is any synced-low cycle while peripherals are out of reset.
    int q0 = 0, q1 = 0, run = 0, m_lost = 0, m_cnt = 0;
    int ls;
    bit m_per = 0, m_core = 0, started = 0, loss;
    always @(posedge clk) begin
        started = 1'b1;
        if (!resetn) begin
            q0 = 0; q1 = 0; run = 0; m_lost = 0; m_cnt = 0;
        end else begin
            ls = q1;
            loss = m_per && (ls == 0);
            if (loss) begin
                m_lost = 1;
                m_cnt = clr ? 1 : (m_cnt < CMAX ? m_cnt + 1 : CMAX);
            end else if (clr) begin
                m_lost = 0;
                m_cnt = 0;
            end
            run = ls ? run + 1 : 0;
            q1 = q0;
            q0 = int'(locked);
        end
        m_per  = run >= S + 1;
        m_core = run >= S + 1 + G;
    end
    always @(negedge clk) begin
        if (started) begin
            chk("m_periph_resetn", periph_resetn, m_per);
            chk("m_core_resetn", core_resetn, m_core);
            chk("m_ready", ready, m_core);
            chk("m_lock_lost", lock_lost, m_lost);
            chk("m_loss_cnt", loss_cnt, CNT_EN ? m_cnt : 0);
        end
    end
    task automatic go(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask
    initial begin
        go(1);
        chk("rst_periph", periph_resetn, 0);
        chk("rst_core", core_resetn, 0);
        chk("rst_ready", ready, 0);
        chk("rst_lost", lock_lost, 0);
        chk("rst_cnt", loss_cnt, 0);
        go(2);  resetn = 1'b1;
        go(10); locked = 1'b1;
        go(28); chk("seq1_periph_c28", periph_resetn, 0);
        go(29); chk("seq1_periph_c29", periph_resetn, 1);
                chk("seq1_core_c29", core_resetn, 0);
        go(32); chk("seq1_core_c32", core_resetn, 0);
        go(33); chk("seq1_core_c33", core_resetn, 1);
                chk("seq1_ready_c33", ready, 1);
                chk("seq1_lost_c33", lock_lost, 0);
        go(40); locked = 1'b0;
        go(42); chk("loss_periph_c42", periph_resetn, 1);
        go(43); chk("loss_periph_c43", periph_resetn, 0);
                chk("loss_core_c43", core_resetn, 0);
                chk("loss_ready_c43", ready, 0);
                chk("loss_lost_c43", lock_lost, 1);
                chk("loss_cnt_c43", loss_cnt, CNT_EN ? 1 : 0);
        go(45); locked = 1'b1;
        go(63); chk("relock_periph_c63", periph_resetn, 0);
        go(64); chk("relock_periph_c64", periph_resetn, 1);
        go(68); chk("relock_core_c68", core_resetn, 1);
        go(70); locked = 1'b0;
        go(75); clr = 1'b1;
        go(76); clr = 1'b0;
                chk("clr_lost_c76", lock_lost, 0);
                chk("clr_cnt_c76", loss_cnt, 0);
        go(80); locked = 1'b1;
        go(88); locked = 1'b0;
        go(89); locked = 1'b1;
        go(99);  chk("glitch_periph_c99", periph_resetn, 0);
        go(107); chk("glitch_periph_c107", periph_resetn, 0);
        go(108); chk("glitch_periph_c108", periph_resetn, 1);
                 chk("glitch_lost_c108", lock_lost, 0);
                 chk("glitch_cnt_c108", loss_cnt, 0);
        go(112); chk("glitch_core_c112", core_resetn, 1);
        for (int i = 0; i < 5; i++) begin
            go(120 + 35 * i); locked = 1'b0;
            go(123 + 35 * i);
            chk("sat_periph", periph_resetn, 0);
            chk("sat_cnt", loss_cnt, CNT_EN ? (i + 1 < CMAX ? i + 1 : CMAX) : 0);
            go(125 + 35 * i); locked = 1'b1;
        end
        go(300); chk("sat_core_c300", core_resetn, 1);
                 chk("sat_cnt_c300", loss_cnt, CNT_EN ? 3 : 0);
                 locked = 1'b0;
        go(302); clr = 1'b1;
        go(303); clr = 1'b0;
                 chk("coinc_lost_c303", lock_lost, 1);
                 chk("coinc_cnt_c303", loss_cnt, CNT_EN ? 1 : 0);
        go(305); locked = 1'b1;
        go(310); clr = 1'b1;
        go(311); clr = 1'b0;
                 chk("clr2_lost_c311", lock_lost, 0);
                 chk("clr2_cnt_c311", loss_cnt, 0);
        go(324); chk("pre_rst_periph_c324", periph_resetn, 1);
        go(325); resetn = 1'b0;
        go(326); resetn = 1'b1;
                 chk("midrst_periph_c326", periph_resetn, 0);
                 chk("midrst_core_c326", core_resetn, 0);
                 chk("midrst_ready_c326", ready, 0);
        go(344); chk("restart_periph_c344", periph_resetn, 0);
        go(345); chk("restart_periph_c345", periph_resetn, 1);
        go(348); chk("restart_core_c348", core_resetn, 0);
        go(349); chk("restart_core_c349", core_resetn, 1);
        go(360);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
